// File: rtl/pc_seq_pkg.sv
// Shared encodings and default widths for pc_sequencer and call_stack.
package pc_seq_pkg;

  localparam int unsigned INSTR_ADDR_SIZE_DEF = 10;
  localparam int unsigned STACK_PTR_WIDTH_DEF = 6;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HALT   = 3'd5
  } pc_op_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_call_depth_counter.sv
// Live call_stack entry counter with full/empty compares (PC_SEQ_DEPTH_CHECK_EN builds only).
module call_depth_counter #(
  parameter int unsigned STACK_PTR_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  input  logic                     dec,
  output logic [STACK_PTR_WIDTH:0] depth,
  output logic                     full,
  output logic                     empty
);

  localparam logic [STACK_PTR_WIDTH:0] DepthOne = {{STACK_PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [STACK_PTR_WIDTH:0] DepthMax = {1'b1, {STACK_PTR_WIDTH{1'b0}}};

  logic [STACK_PTR_WIDTH:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (inc) begin
      depth_d = depth_q + DepthOne;
    end else if (dec) begin
      depth_d = depth_q - DepthOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  assign depth = depth_q;
  assign full  = (depth_q == DepthMax);
  assign empty = (depth_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// PC / control-flow sequencer driving call_stack; optional depth checking under
// PC_SEQ_DEPTH_CHECK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned INSTRUCTION_ADDR_SIZE = INSTR_ADDR_SIZE_DEF,
  parameter int unsigned STACK_PTR_WIDTH       = STACK_PTR_WIDTH_DEF,
  parameter logic [INSTRUCTION_ADDR_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic [2:0]                       op,
  input  logic                             branch_taken,
  input  logic [INSTRUCTION_ADDR_SIZE-1:0] target,
  input  logic [INSTRUCTION_ADDR_SIZE-1:0] stack_top,
  output logic [INSTRUCTION_ADDR_SIZE-1:0] stack_addr,
  output logic                             stack_en,
  output logic                             stack_push,
  output logic [INSTRUCTION_ADDR_SIZE-1:0] pc,
  output logic                             halted,
  output logic                             fault,
  output logic [STACK_PTR_WIDTH:0]         call_depth
);

  localparam logic [INSTRUCTION_ADDR_SIZE-1:0] PcOne = {{(INSTRUCTION_ADDR_SIZE-1){1'b0}}, 1'b1};

  pc_state_e                        state_q, state_d;
  logic [INSTRUCTION_ADDR_SIZE-1:0] pc_q, pc_d;
  logic [INSTRUCTION_ADDR_SIZE-1:0] next_seq;
  logic                             call_err, ret_err;

  assign next_seq = pc_q + PcOne;

`ifdef PC_SEQ_DEPTH_CHECK_EN
  logic depth_full, depth_empty;

  call_depth_counter #(
    .STACK_PTR_WIDTH(STACK_PTR_WIDTH)
  ) u_call_depth_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stack_en & stack_push),
    .dec  (stack_en & ~stack_push),
    .depth(call_depth),
    .full (depth_full),
    .empty(depth_empty)
  );

  assign call_err = depth_full;
  assign ret_err  = depth_empty;
  assign fault    = (state_q == ST_FAULT);
`else
  assign call_err   = 1'b0;
  assign ret_err    = 1'b0;
  assign fault      = 1'b0;
  assign call_depth = '0;
`endif

  // Gating on rst_n keeps stack_en low for the whole reset window, even mid-cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stack_en   = 1'b0;
    stack_push = 1'b0;
    stack_addr = pc_q;
    if (rst_n && (state_q == ST_RUN) && !stall) begin
      case (op)
        OP_JUMP:   pc_d = target;
        OP_BRANCH: pc_d = branch_taken ? target : next_seq;
        OP_CALL: begin
          if (call_err) begin
            state_d = ST_FAULT;
          end else begin
            stack_en   = 1'b1;
            stack_push = 1'b1;
            stack_addr = next_seq;
            pc_d       = target;
          end
        end
        OP_RET: begin
          if (ret_err) begin
            state_d = ST_FAULT;
          end else begin
            stack_en   = 1'b1;
            stack_addr = stack_top;
            pc_d       = stack_top;
          end
        end
        OP_HALT:   state_d = ST_HALTED;
        default:   pc_d = next_seq;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver queues hand-computed expectations,
// negedge monitor pops and compares.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  typedef struct packed {
    logic       en;
    logic       push;
    logic [9:0] addr;
    logic [9:0] pc;
    logic       halted;
    logic       fault;
    logic [6:0] depth;
  } obs_t;

`ifdef PC_SEQ_DEPTH_CHECK_EN
  localparam bit DepthCk = 1'b1;
`else
  localparam bit DepthCk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] op = 3'd0;
  logic       branch_taken = 1'b0;
  logic [9:0] target = '0;
  logic [9:0] stack_top = '0;
  logic [9:0] stack_addr;
  logic       stack_en;
  logic       stack_push;
  logic [9:0] pc;
  logic       halted;
  logic       fault;
  logic [6:0] call_depth;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  pc_sequencer #(
    .INSTRUCTION_ADDR_SIZE(10),
    .STACK_PTR_WIDTH(6),
    .RESET_VECTOR(10'd0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .op(op),
    .branch_taken(branch_taken),
    .target(target),
    .stack_top(stack_top),
    .stack_addr(stack_addr),
    .stack_en(stack_en),
    .stack_push(stack_push),
    .pc(pc),
    .halted(halted),
    .fault(fault),
    .call_depth(call_depth)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic en, input logic push, input logic [9:0] addr,
                              input logic [9:0] p, input logic h, input logic f,
                              input logic [6:0] d);
    obs_t o;
    o = '{en: en, push: push, addr: addr, pc: p, halted: h, fault: f, depth: d};
    return o;
  endfunction

  function automatic logic [6:0] dep(input int d);
    return DepthCk ? 7'(d) : 7'd0;
  endfunction

  // Drive one cycle's inputs just after the edge; rst level applied slightly later so a
  // falling reset lands mid-cycle.
  task automatic vec(input string nm, input logic r, input logic [2:0] o, input logic bt,
                     input logic [9:0] tg, input logic [9:0] top, input logic st,
                     input obs_t e);
    @(posedge clk);
    #1;
    op = o; branch_taken = bt; target = tg; stack_top = top; stall = st;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
    rst_n = r;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t a, e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = mk(stack_en, stack_push, stack_addr, pc, halted, fault, call_depth);
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got en=%0b push=%0b addr=%0d pc=%0d halted=%0b fault=%0b depth=%0d, want en=%0b push=%0b addr=%0d pc=%0d halted=%0b fault=%0b depth=%0d",
                 nm, a.en, a.push, a.addr, a.pc, a.halted, a.fault, a.depth,
                 e.en, e.push, e.addr, e.pc, e.halted, e.fault, e.depth);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want summary");
    $fatal(1);
  end

  initial begin
    vec("reset_call",  1'b0, OP_CALL,   1'b0, 10'd77,   10'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    vec("seq0",        1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    vec("seq1",        1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 1, 1, 0, 0, 0));
    vec("seq2",        1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 2, 2, 0, 0, 0));
    vec("jump1023",    1'b1, OP_JUMP,   1'b0, 10'd1023, 10'd0, 1'b0, mk(0, 0, 3, 3, 0, 0, 0));
    vec("seq_wrap",    1'b1, 3'd7,      1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 1023, 1023, 0, 0, 0));
    vec("jump5",       1'b1, OP_JUMP,   1'b0, 10'd5,    10'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    vec("call67",      1'b1, OP_CALL,   1'b0, 10'd67,   10'd0, 1'b0, mk(1, 1, 6, 5, 0, 0, 0));
    vec("ret6",        1'b1, OP_RET,    1'b0, 10'd0,    10'd6, 1'b0, mk(1, 0, 6, 67, 0, 0, dep(1)));
    vec("br_not",      1'b1, OP_BRANCH, 1'b0, 10'd100,  10'd0, 1'b0, mk(0, 0, 6, 6, 0, 0, 0));
    vec("br_taken",    1'b1, OP_BRANCH, 1'b1, 10'd100,  10'd0, 1'b0, mk(0, 0, 7, 7, 0, 0, 0));
    vec("call_stall",  1'b1, OP_CALL,   1'b0, 10'd300,  10'd0, 1'b1, mk(0, 0, 100, 100, 0, 0, 0));
    vec("jump9",       1'b1, OP_JUMP,   1'b0, 10'd9,    10'd0, 1'b0, mk(0, 0, 100, 100, 0, 0, 0));
    vec("halt",        1'b1, OP_HALT,   1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 9, 9, 0, 0, 0));
    vec("halt_call",   1'b1, OP_CALL,   1'b0, 10'd50,   10'd0, 1'b0, mk(0, 0, 9, 9, 1, 0, 0));
    vec("halt_jump",   1'b1, OP_JUMP,   1'b0, 10'd200,  10'd0, 1'b0, mk(0, 0, 9, 9, 1, 0, 0));
    vec("halt_hold",   1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 9, 9, 1, 0, 0));
    vec("rst_halted",  1'b0, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    vec("post_rst0",   1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    vec("post_rst1",   1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 1, 1, 0, 0, 0));
    vec("call40",      1'b1, OP_CALL,   1'b0, 10'd40,   10'd0, 1'b0, mk(1, 1, 3, 2, 0, 0, 0));
    vec("rst_mid_call",1'b0, OP_CALL,   1'b0, 10'd80,   10'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    vec("after_rst0",  1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    vec("after_rst1",  1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 1, 1, 0, 0, 0));
`ifdef PC_SEQ_DEPTH_CHECK_EN
    vec("rst_a",       1'b0, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    vec("ret_under",   1'b1, OP_RET,    1'b0, 10'd0,    10'd55, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    vec("fault_seq",   1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0));
    vec("fault_call",  1'b1, OP_CALL,   1'b0, 10'd20,   10'd0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0));
    vec("rst_b",       1'b0, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 64; i++) begin
      logic [9:0] p;
      p = (i == 0) ? 10'd0 : 10'(99 + i);
      vec($sformatf("call_fill%0d", i), 1'b1, OP_CALL, 1'b0, 10'(100 + i), 10'd0, 1'b0,
          mk(1, 1, p + 10'd1, p, 0, 0, 7'(i)));
    end
    vec("call_over",   1'b1, OP_CALL,   1'b0, 10'd500,  10'd0, 1'b0, mk(0, 0, 163, 163, 0, 0, 64));
    vec("over_hold",   1'b1, OP_SEQ,    1'b0, 10'd0,    10'd0, 1'b0, mk(0, 0, 163, 163, 0, 1, 64));
`endif
    @(posedge clk);
    @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
